// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters (CPU load/store stage on port 0,
// DMA/test loader on port 1), the dmem_arbiter and the word-wide data memory.
// The master side is the environment (requesters plus memory model),
// the slave side is the arbiter itself.
interface dmem_arbiter_if #(
  parameter int SIZE_WORD = 2
);
  localparam int AW = $clog2(4 * SIZE_WORD);

  // Requester port 0
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [31:0]   wdata0;
  logic          gnt0;
  logic          ack0;
  logic          err0;
  logic [31:0]   rdata0;

  // Requester port 1
  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [31:0]   wdata1;
  logic          gnt1;
  logic          ack1;
  logic          err1;
  logic [31:0]   rdata1;

  // Memory side
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_write;
  logic          mem_read;
  logic [31:0]   mem_rdata;

  modport master (
    output req0, we0, addr0, wdata0,
    input  gnt0, ack0, err0, rdata0,
    output req1, we1, addr1, wdata1,
    input  gnt1, ack1, err1, rdata1,
    input  mem_addr, mem_wdata, mem_write, mem_read,
    output mem_rdata
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    output gnt0, ack0, err0, rdata0,
    input  req1, we1, addr1, wdata1,
    output gnt1, ack1, err1, rdata1,
    output mem_addr, mem_wdata, mem_write, mem_read,
    input  mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the big-endian,
// word-wide data memory. One request is latched per access; the memory
// controls are held for MEM_LAT cycles, then the winning port receives an
// ack pulse (and, for loads, the captured read word). Misaligned requests
// take a one-cycle error path with no memory activity.
module dmem_arbiter #(
  parameter int SIZE_WORD = 2,
  parameter int MEM_LAT   = 2
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  localparam int AW = $clog2(4 * SIZE_WORD);
  localparam int CW = $clog2(MEM_LAT) + 1;

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_t;

  // Winner on a tie is the port that did not win last time; a lone
  // requester always wins.
  function automatic logic pick_port(input logic r0, input logic r1,
                                     input logic last);
    logic p;
    p = 1'b0;
    case ({r1, r0})
      2'b01:   p = 1'b0;
      2'b10:   p = 1'b1;
      2'b11:   p = ~last;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  // One-hot pulse vector for a port index, bit 0 = port 0.
  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

  // Word accesses need the two low byte-address bits clear.
  function automatic logic is_aligned(input logic [AW-1:0] a);
    return (a[1:0] == 2'b00);
  endfunction

  state_t        state_r;
  logic          owner_r;
  logic          last_r;
  logic [CW-1:0] cnt_r;
  logic [AW-1:0] addr_r;
  logic          we_r;
  logic [31:0]   wdata_r;
  logic [1:0]    gnt_r;
  logic [1:0]    ack_r;
  logic [1:0]    err_r;
  logic [31:0]   rdata0_r;
  logic [31:0]   rdata1_r;
  logic          mem_read_r;
  logic          mem_write_r;

  logic          any_req_s;
  logic          sel_s;
  logic [AW-1:0] sel_addr_s;
  logic          sel_we_s;
  logic [31:0]   sel_wdata_s;

  // Request selection: only consulted while IDLE.
  assign any_req_s   = bus.req0 | bus.req1;
  assign sel_s       = pick_port(bus.req0, bus.req1, last_r);
  assign sel_addr_s  = sel_s ? bus.addr1  : bus.addr0;
  assign sel_we_s    = sel_s ? bus.we1    : bus.we0;
  assign sel_wdata_s = sel_s ? bus.wdata1 : bus.wdata0;

  // Sequencer FSM: arbitration, access window timing and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      owner_r     <= 1'b0;
      last_r      <= 1'b1;
      cnt_r       <= CNT_ZERO;
      addr_r      <= {AW{1'b0}};
      we_r        <= 1'b0;
      wdata_r     <= 32'h0000_0000;
      gnt_r       <= 2'b00;
      ack_r       <= 2'b00;
      err_r       <= 2'b00;
      rdata0_r    <= 32'h0000_0000;
      rdata1_r    <= 32'h0000_0000;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
    end else begin
      // Handshake outputs are single-cycle pulses unless set below.
      gnt_r <= 2'b00;
      ack_r <= 2'b00;
      err_r <= 2'b00;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            owner_r <= sel_s;
            last_r  <= sel_s;
            addr_r  <= sel_addr_s;
            we_r    <= sel_we_s;
            wdata_r <= sel_wdata_s;
            gnt_r   <= port_onehot(sel_s);
            cnt_r   <= CNT_ZERO;
            if (is_aligned(sel_addr_s)) begin
              state_r     <= BUSY;
              mem_read_r  <= ~sel_we_s;
              mem_write_r <= sel_we_s;
            end else begin
              state_r     <= ERR;
              mem_read_r  <= 1'b0;
              mem_write_r <= 1'b0;
            end
          end else begin
            state_r     <= IDLE;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
          end
        end
        BUSY: begin
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            // Last cycle of the window: memory data is valid now.
            if (!we_r) begin
              if (owner_r) begin
                rdata1_r <= bus.mem_rdata;
              end else begin
                rdata0_r <= bus.mem_rdata;
              end
            end else begin
              rdata0_r <= rdata0_r;
            end
            state_r     <= IDLE;
            ack_r       <= port_onehot(owner_r);
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
          end else begin
            state_r <= BUSY;
          end
        end
        ERR: begin
          state_r     <= IDLE;
          ack_r       <= port_onehot(owner_r);
          err_r       <= port_onehot(owner_r);
          mem_read_r  <= 1'b0;
          mem_write_r <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= CNT_ZERO;
          mem_read_r  <= 1'b0;
          mem_write_r <= 1'b0;
        end
      endcase
    end
  end

  // Memory address/data come straight from the request latches so they
  // hold their last value outside the access window.
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;
  assign bus.mem_read  = mem_read_r;
  assign bus.mem_write = mem_write_r;

  assign bus.gnt0   = gnt_r[0];
  assign bus.gnt1   = gnt_r[1];
  assign bus.ack0   = ack_r[0];
  assign bus.ack1   = ack_r[1];
  assign bus.err0   = err_r[0];
  assign bus.err1   = err_r[1];
  assign bus.rdata0 = rdata0_r;
  assign bus.rdata1 = rdata1_r;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the byte-addressed, big-endian, word-wide data memory. Port 0 is the CPU load/store stage and port 1 is the DMA/test-loader port. The block arbitrates round-robin, latches one request, and holds the memory controls stable for a fixed access window. It then returns read data and a completion pulse to the winning port.

## Interface
- SIZE_WORD, 2, memory depth in 32-bit words (4*SIZE_WORD bytes)
- MEM_LAT, 2, cycles the memory controls are held per access (≥1)
- AW, $clog2(4*SIZE_WORD), byte-address width (derived, not overridden)
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0 / req1  in  1  access request, level, sampled only in IDLE
- we0 / we1  in  1  1 = store word, 0 = load word
- addr0 / addr1  in  AW  byte address, must be word-aligned
- wdata0 / wdata1  in  32  store data
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted, inputs latched
- ack0 / ack1  out  1  one-cycle pulse: access complete
- err0 / err1  out  1  one-cycle pulse with ack: misaligned, no access done
- rdata0 / rdata1  out  32  load result, held until next load to that port
- mem_addr  out  AW  to memory address
- mem_wdata  out  32  to memory write data
- mem_write  out  1  to memory write enable
- mem_read  out  1  to memory read enable
- mem_rdata  in  32  from memory read data

## Operation
- FSM states: IDLE, BUSY, ERR. Registers: owner (1 bit), last (1 bit), cnt (clog2(MEM_LAT)+1 bits), latched addr/we/wdata.
- IDLE, no req: stay IDLE.
- IDLE, one req: that port wins.
- IDLE, both req: the port not equal to last wins.
- On a win: latch addr/we/wdata, set owner, set last=owner, and pulse gnt for the owner on the next cycle.
  - addr[1:0]==0 → BUSY with cnt=0.
  - addr[1:0]!=0 → ERR.
- BUSY: drive mem_addr/mem_wdata from the latches.
  - Load: mem_read=1, mem_write=0.
  - Store: mem_write=1, mem_read=0.
  - mem_read and mem_write are never both 1.
  - cnt increments each cycle. When cnt==MEM_LAT-1: load captures mem_rdata into rdata of the owner, then → IDLE with ack for the owner.
- ERR: single cycle, no mem activity → IDLE with ack and err for the owner. rdata is unchanged.
- Stores never modify rdata.
- A req still high in the IDLE cycle that carries ack is a new request and may be granted again. Requesters drop req after gnt to avoid reissue.
- Outside BUSY: mem_read=mem_write=0, and mem_addr/mem_wdata hold their last latched values.

## Timing
- Req sampled at the edge ending cycle T.
- Cycle T+1: gnt high and state BUSY (memory controls valid from T+1).
- Memory controls are stable for cycles T+1..T+MEM_LAT.
- mem_rdata is sampled at the edge ending T+MEM_LAT.
- Cycle T+MEM_LAT+1: ack high in IDLE, rdata valid.
- Back-to-back throughput: one access per MEM_LAT+1 cycles.
- Misaligned path: gnt at T+1 (ERR), ack+err at T+2.
- gnt, ack and err are registered and high for exactly one cycle. At most one port's gnt/ack is high in any cycle.
- Reset value of all outputs is 0: gnt, ack, err, rdata, mem_addr, mem_wdata, mem_read, mem_write. State=IDLE, cnt=0, last=1 (port 0 wins the first tie).
- rst mid-BUSY: the next cycle is IDLE with mem_write/mem_read at 0. The aborted access gets no ack, and its store is not guaranteed.
- rst has priority over every req in the same cycle.

## Test plan
- Reset then single load: req0 with we0=0, addr0=4, memory word 4 = 0xDEADBEEF, MEM_LAT=2 → gnt0 at T+1, mem_read high at T+1..T+2, ack0 at T+3, rdata0=0xDEADBEEF, rdata1=0.
- Store then load from the other port: port1 stores 0x12345678 at addr 0, then port0 loads addr 0 → mem_write high 2 cycles with mem_wdata=0x12345678, then rdata0=0x12345678. rdata1 stays 0 after the store.
- Contention: req0 and req1 held high continuously, one access each → grants alternate 0,1,0,1. The first grant goes to port 0 after reset. Grants are spaced MEM_LAT+1 cycles apart.
- Misaligned: req1 with addr1=6 → gnt1 at T+1, ack1 and err1 at T+2, mem_read and mem_write never asserted, rdata1 unchanged.
- Reset mid-access: rst during the second BUSY cycle of a store → the next cycle has mem_write=0 and state IDLE. No ack0 is issued, and a fresh req0 afterwards is granted normally.
- Exclusivity sweep: random req/we/addr on both ports for 1000 cycles.
  - mem_read&mem_write never high together.
  - gnt0&gnt1 and ack0&ack1 never high together.
  - Every accepted, non-reset access gets exactly one ack.
